reg_rr_arbiter: RTL and testbench

// Shares one register-interface target (req: addr/write/wdata/wstrb/valid; rsp: rdata/error/ready)

---
 rtl/reg_arb_pkg.sv | 29 ++
 rtl/reg_rr_pick.sv | 39 +++
 rtl/reg_rr_arbiter.sv | 103 ++++++++++
 tb/tb_reg_rr_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_arb_pkg.sv
// Register-interface request/response types and arbiter state encoding
// shared by the reg_rr_arbiter slice.
package reg_arb_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 write;
        logic [DataWidth-1:0] wdata;
        logic [StrbWidth-1:0] wstrb;
        logic                 valid;
    } reg_req_t;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic                 error;
        logic                 ready;
    } reg_rsp_t;

    typedef enum logic [1:0] {
        Idle = 2'b00,
        Busy = 2'b01,
        Resp = 2'b10
    } state_t;

endpackage

// File: rtl/reg_rr_pick.sv
// Round-robin winner selection: first valid index at or after ptr_i, modulo NumReq.
// The valid vector is rotated down by the pointer, then the lowest set bit is located.
module reg_rr_pick
    import reg_arb_pkg::*;
#(
    parameter int unsigned NumReq   = 2,
    parameter int unsigned IdxWidth = 1
) (
    input  logic [NumReq-1:0]   valid_i,
    input  logic [IdxWidth-1:0] ptr_i,
    output logic [IdxWidth-1:0] idx_o,
    output logic                any_o
);

    localparam int unsigned SumWidth = IdxWidth + 1;
    localparam logic [SumWidth-1:0] NumReqW = SumWidth'(NumReq);

    logic [NumReq-1:0]   rot;
    logic [SumWidth-1:0] ofs;
    logic [SumWidth-1:0] sum;

    always_comb begin
        rot = NumReq'({valid_i, valid_i} >> ptr_i);
        ofs = '0;
        // Descending scan so the lowest set bit of the rotated vector wins.
        for (int unsigned i = NumReq; i > 0; i--) begin
            if (rot[i-1]) begin
                ofs = SumWidth'(i - 1);
            end
        end
        sum = {1'b0, ptr_i} + ofs;
        if (sum >= NumReqW) begin
            sum = sum - NumReqW;
        end
        idx_o = sum[IdxWidth-1:0];
        any_o = |valid_i;
    end

endmodule

// File: rtl/reg_rr_arbiter.sv
// Round-robin arbiter sharing one register-interface target between NumReq requesters.
// Grant is locked per transaction; the response is registered back to the winner.
module reg_rr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int unsigned NumReq        = 2,
    parameter type         req_t         = reg_req_t,
    parameter type         rsp_t         = reg_rsp_t,
    parameter bit          ProtocolCheck = 1'b1,
    localparam int unsigned IdxWidth     = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  req_t                src_req_i [NumReq],
    output rsp_t                src_rsp_o [NumReq],
    output req_t                dst_req_o,
    input  rsp_t                dst_rsp_i,
    output logic [IdxWidth-1:0] gnt_idx_o,
    output logic                busy_o
);

    state_t              state_q;
    logic [IdxWidth-1:0] gnt_q;
    logic [IdxWidth-1:0] ptr_q;
    rsp_t                rsp_q;

    logic [NumReq-1:0]   valid_vec;
    logic [IdxWidth-1:0] pick_idx;
    logic                pick_any;

    always_comb begin
        valid_vec = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            valid_vec[i] = src_req_i[i].valid;
        end
    end

    reg_rr_pick #(
        .NumReq   (NumReq),
        .IdxWidth (IdxWidth)
    ) u_pick (
        .valid_i (valid_vec),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= Idle;
            gnt_q   <= '0;
            ptr_q   <= '0;
            rsp_q   <= '0;
        end else begin
            case (state_q)
                Idle: begin
                    if (pick_any) begin
                        gnt_q   <= pick_idx;
                        state_q <= Busy;
                    end
                end
                Busy: begin
                    if (dst_rsp_i.ready) begin
                        rsp_q   <= dst_rsp_i;
                        state_q <= Resp;
                    end
                end
                Resp: begin
                    ptr_q   <= (gnt_q == IdxWidth'(NumReq - 1)) ? '0 : gnt_q + 1'b1;
                    state_q <= Idle;
                end
                default: state_q <= Idle;
            endcase
        end
    end

    // Outputs decode only registered state, so reset clears dst valid asynchronously.
    always_comb begin
        dst_req_o = '0;
        if (state_q == Busy) begin
            dst_req_o       = src_req_i[gnt_q];
            dst_req_o.valid = 1'b1;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NumReq; i++) begin
            src_rsp_o[i]       = rsp_q;
            src_rsp_o[i].ready = (state_q == Resp) && (gnt_q == IdxWidth'(i));
        end
    end

    assign gnt_idx_o = gnt_q;
    assign busy_o    = (state_q == Busy) || (state_q == Resp);

    always_ff @(posedge clk_i) begin
        if (ProtocolCheck && !rst_i && (state_q == Busy)) begin
            assert (src_req_i[gnt_q].valid)
                else $error("reg_rr_arbiter: requester %0d dropped valid before ready", gnt_q);
        end
    end

endmodule

// File: tb/tb_reg_rr_arbiter.sv
// Self-checking bench for reg_rr_arbiter with three requesters: vector table plus
// directed sequences, responses checked against a scoreboard queue.
module tb_reg_rr_arbiter;
    import reg_arb_pkg::*;

    localparam int unsigned N  = 3;
    localparam int unsigned IW = 2;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [31:0]   rdata;
        logic          err;
    } exp_t;

    typedef struct {
        logic [N-1:0] mask;
        int unsigned  wait_cyc;
        logic         err;
        logic [31:0]  base;
        int unsigned  o0;
        int unsigned  o1;
        int unsigned  o2;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    reg_req_t      src_req [N];
    reg_rsp_t      src_rsp [N];
    reg_req_t      dst_req;
    reg_rsp_t      dst_rsp;
    logic [IW-1:0] gnt_idx;
    logic          busy;

    always #5 clk = ~clk;

    reg_rr_arbiter #(
        .NumReq        (N),
        .req_t         (reg_req_t),
        .rsp_t         (reg_rsp_t),
        .ProtocolCheck (1'b0)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .src_req_i (src_req),
        .src_rsp_o (src_rsp),
        .dst_req_o (dst_req),
        .dst_rsp_i (dst_rsp),
        .gnt_idx_o (gnt_idx),
        .busy_o    (busy)
    );

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    int unsigned tick_no = 0;
    exp_t        exp_q [$];
    int unsigned tgt_wait = 0;
    int unsigned wait_cnt = 0;
    int unsigned tgt_seq = 0;
    int unsigned dst_rdy_tick = 0;
    int unsigned busy_ticks = 0;
    logic [31:0] tgt_base = '0;
    logic        tgt_err = 1'b0;
    logic        stray = 1'b0;
    int unsigned keep_valid = 0;
    int unsigned rdy_tick [N];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (tick %0d)", name, act, exp, tick_no);
        end
    endtask

    function automatic reg_req_t mk_req(input int unsigned i, input int unsigned v);
        reg_req_t r;
        r.addr  = 32'h100 * (i + 1) + v * 4;
        r.write = ((v % 2) == 0);
        r.wdata = 32'hC0DE_0000 + i * 16 + v;
        r.wstrb = 4'(v) | 4'h1;
        r.valid = 1'b1;
        return r;
    endfunction

    task automatic push(input int unsigned idx, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.idx   = IW'(idx);
        e.rdata = rdata;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    task automatic tgt_cfg(input int unsigned w, input logic [31:0] base, input logic err);
        tgt_wait = w;
        tgt_base = base;
        tgt_err  = err;
        tgt_seq  = 0;
        wait_cnt = 0;
    endtask

    // One clock: target model reacts after the edge, responses sampled on the falling edge.
    task automatic tick();
        exp_t        e;
        int unsigned nr;
        @(posedge clk);
        tick_no++;
        #1;
        if (dst_req.valid) begin
            busy_ticks++;
            if (wait_cnt == tgt_wait) begin
                dst_rsp.ready = 1'b1;
                dst_rsp.rdata = tgt_base + tgt_seq;
                dst_rsp.error = tgt_err;
                tgt_seq++;
                wait_cnt = 0;
                dst_rdy_tick = tick_no;
            end else begin
                dst_rsp.ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            dst_rsp.ready = stray;
            dst_rsp.rdata = 32'h5A5A_5A5A;
            dst_rsp.error = stray;
        end
        @(negedge clk);
        nr = 0;
        for (int i = 0; i < N; i++) begin
            if (src_rsp[i].ready) begin
                nr++;
                chk("rsp_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_idx", i, e.idx);
                    chk("rsp_rdata", src_rsp[i].rdata, e.rdata);
                    chk("rsp_error", src_rsp[i].error, e.err);
                end
                rdy_tick[i] = tick_no;
                if (keep_valid > 0) keep_valid--;
                else src_req[i].valid = 1'b0;
            end
        end
        if (nr > 1) chk("single_ready", nr, 1);
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned b;
        b = budget;
        while (exp_q.size() != 0 && b > 0) begin
            tick();
            b--;
        end
        chk("drain_done", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt [8];
        int unsigned ord [3];
        reg_req_t    r;
        int unsigned t0;

        for (int i = 0; i < N; i++) begin
            src_req[i] = '0;
            rdy_tick[i] = 0;
        end
        dst_rsp = '0;

        // Expected order assumes the pointer sits at 1 after the first directed transaction.
        vt[0] = '{3'b001, 0, 1'b0, 32'h3000_0000, 0, 3, 3};
        vt[1] = '{3'b111, 0, 1'b0, 32'h3100_0000, 1, 2, 0};
        vt[2] = '{3'b101, 0, 1'b0, 32'h3200_0000, 2, 0, 3};
        vt[3] = '{3'b011, 2, 1'b1, 32'h3300_0000, 1, 0, 3};
        vt[4] = '{3'b100, 1, 1'b0, 32'h3400_0000, 2, 3, 3};
        vt[5] = '{3'b110, 0, 1'b0, 32'h3500_0000, 1, 2, 3};
        vt[6] = '{3'b010, 0, 1'b1, 32'h3600_0000, 1, 3, 3};
        vt[7] = '{3'b011, 1, 1'b0, 32'h3700_0000, 0, 1, 3};

        // Reset state
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt_idx, 0);
        chk("rst_dst_req_zero", dst_req == '0, 1);
        for (int i = 0; i < N; i++) chk("rst_src_rsp_zero", src_rsp[i] == '0, 1);
        rst = 1'b0;

        // Single write from req0, zero-wait target
        tgt_cfg(0, 32'h1111_0000, 1'b0);
        push(0, 32'h1111_0000, 1'b0);
        src_req[0] = '{addr: 32'h40, write: 1'b1, wdata: 32'h1234_5678, wstrb: 4'h3, valid: 1'b1};
        tick();
        chk("t1_c1_busy", busy, 1);
        chk("t1_c1_dst_valid", dst_req.valid, 1);
        chk("t1_c1_dst_addr", dst_req.addr, 32'h40);
        chk("t1_c1_dst_write", dst_req.write, 1);
        chk("t1_c1_dst_wdata", dst_req.wdata, 32'h1234_5678);
        chk("t1_c1_dst_wstrb", dst_req.wstrb, 4'h3);
        chk("t1_c1_gnt", gnt_idx, 0);
        chk("t1_c1_src_ready", src_rsp[0].ready, 0);
        tick();
        chk("t1_c2_busy", busy, 1);
        chk("t1_c2_dst_valid", dst_req.valid, 0);
        chk("t1_c2_src_ready", src_rsp[0].ready, 1);
        tick();
        chk("t1_c3_busy", busy, 0);
        chk("t1_c3_src_ready", src_rsp[0].ready, 0);
        chk("t1_sb_empty", exp_q.size(), 0);

        // Vector table
        for (int v = 0; v < 8; v++) begin
            tgt_cfg(vt[v].wait_cyc, vt[v].base, vt[v].err);
            ord[0] = vt[v].o0;
            ord[1] = vt[v].o1;
            ord[2] = vt[v].o2;
            for (int k = 0; k < 3; k++) begin
                if (ord[k] < 3) push(ord[k], vt[v].base + 32'(k), vt[v].err);
            end
            for (int i = 0; i < N; i++) begin
                if (vt[v].mask[i]) src_req[i] = mk_req(i, v);
            end
            tick();
            r = mk_req(vt[v].o0, v);
            chk("vec_busy", busy, 1);
            chk("vec_first_gnt", gnt_idx, vt[v].o0);
            chk("vec_first_addr", dst_req.addr, r.addr);
            drain(50);
            tick();
            chk("vec_idle_after", busy, 0);
        end

        // Read with 5 stall cycles, error response, from req1
        tgt_cfg(5, 32'hDEAD_BEEF, 1'b1);
        push(1, 32'hDEAD_BEEF, 1'b1);
        src_req[1] = mk_req(1, 21);
        busy_ticks = 0;
        tick();
        chk("t3_gnt", gnt_idx, 1);
        chk("t3_dst_read", dst_req.write, 0);
        drain(20);
        chk("t3_busy_ticks", busy_ticks, 6);
        chk("t3_rsp_latency", rdy_tick[1], dst_rdy_tick + 1);
        chk("t3_rdata", src_rsp[1].rdata, 32'hDEAD_BEEF);
        chk("t3_error", src_rsp[1].error, 1);
        chk("t3_other0_ready", src_rsp[0].ready, 0);
        chk("t3_other2_ready", src_rsp[2].ready, 0);
        tick();
        chk("t3_idle_after", busy, 0);

        // req1 arrives while req0 is in Busy
        tgt_cfg(1, 32'h4000_0000, 1'b0);
        push(0, 32'h4000_0000, 1'b0);
        push(1, 32'h4000_0001, 1'b0);
        src_req[0] = mk_req(0, 30);
        tick();
        r = mk_req(0, 30);
        chk("t4_gnt0", gnt_idx, 0);
        chk("t4_addr0", dst_req.addr, r.addr);
        src_req[1] = mk_req(1, 31);
        tick();
        chk("t4_still_busy", busy, 1);
        chk("t4_gnt_locked", gnt_idx, 0);
        chk("t4_addr_locked", dst_req.addr, r.addr);
        tick();
        chk("t4_resp0_ready", src_rsp[0].ready, 1);
        chk("t4_resp1_not_ready", src_rsp[1].ready, 0);
        chk("t4_resp_dst_valid", dst_req.valid, 0);
        tick();
        chk("t4_idle_gap_busy", busy, 0);
        chk("t4_idle_gap_dst_valid", dst_req.valid, 0);
        tick();
        r = mk_req(1, 31);
        chk("t4_gnt1", gnt_idx, 1);
        chk("t4_addr1", dst_req.addr, r.addr);
        drain(10);
        tick();
        chk("t4_idle_after", busy, 0);

        // Reset asserted during Busy
        tgt_cfg(3, 32'h5000_0000, 1'b0);
        src_req[2] = mk_req(2, 40);
        tick();
        chk("t5_busy_gnt2", gnt_idx, 2);
        chk("t5_dst_valid_pre", dst_req.valid, 1);
        rst = 1'b1;
        #1;
        chk("t5_async_dst_valid", dst_req.valid, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_gnt", gnt_idx, 0);
        wait_cnt = 0;
        tick();
        chk("t5_rst_dst_zero", dst_req == '0, 1);
        push(1, 32'h5000_0000, 1'b0);
        push(2, 32'h5000_0001, 1'b0);
        src_req[1] = mk_req(1, 41);
        tgt_cfg(3, 32'h5000_0000, 1'b0);
        rst = 1'b0;
        tick();
        chk("t5_lowest_after_reset", gnt_idx, 1);
        drain(30);
        tick();
        chk("t5_idle_after", busy, 0);

        // All three valid continuously: two full rounds
        tgt_cfg(0, 32'h2000_0000, 1'b0);
        for (int k = 0; k < 6; k++) push(k % 3, 32'h2000_0000 + 32'(k), 1'b0);
        keep_valid = 3;
        for (int i = 0; i < N; i++) src_req[i] = mk_req(i, 50 + i);
        tick();
        t0 = tick_no;
        chk("t2_first_gnt", gnt_idx, 0);
        drain(40);
        chk("t2_span", rdy_tick[2] - t0, 16);
        tick();
        chk("t2_idle_after", busy, 0);

        // Stray target ready in Idle, then granted valid dropped in Busy
        stray = 1'b1;
        tick();
        chk("t6_stray_busy_a", busy, 0);
        chk("t6_stray_dst_a", dst_req.valid, 0);
        tick();
        chk("t6_stray_busy_b", busy, 0);
        stray = 1'b0;
        tgt_cfg(2, 32'h6000_0000, 1'b0);
        push(1, 32'h6000_0000, 1'b0);
        src_req[1] = mk_req(1, 60);
        tick();
        chk("t6_gnt1", gnt_idx, 1);
        src_req[1].valid = 1'b0;
        tick();
        r = mk_req(1, 60);
        chk("t6_dst_valid_after_drop", dst_req.valid, 1);
        chk("t6_addr_after_drop", dst_req.addr, r.addr);
        drain(10);
        tick();
        chk("t6_idle_after", busy, 0);

        chk("sb_empty_end", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
